// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - SRAM-like instruction bus between the fetch stage and instruction memory
//
// Purpose: bundles the request/response handshake of the instruction bus.
// Signals:
//   inst_req      master -> slave  request valid
//   inst_addr     master -> slave  request address (sampled only with inst_addr_ok)
//   inst_addr_ok  slave  -> master request accepted this cycle
//   inst_data_ok  slave  -> master read data valid this cycle
//   inst_rdata    slave  -> master read data
interface if_fetch_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic              inst_req;
  logic [W_ADDR-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [W_DATA-1:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - MIPS instruction-fetch stage with output register and skid buffer
//
// Purpose: owns the PC, issues one instruction-bus request at a time, and hands
// fetched instructions to decode through a one-entry output register backed by a
// one-entry skid buffer. Applies branch redirects after the delay slot and
// exception/ERET flushes.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   stall                  decode not accepting this cycle
//   flush, flush_addr      exception redirect (highest priority)
//   branch, branch_addr    taken branch from decode
//   ibus                   instruction bus (master side)
//   if_valid/if_pc/if_inst/if_adel  entry held for decode
module if_fetch #(
  parameter int                W_ADDR   = 32,
  parameter int                W_DATA   = 32,
  parameter logic [W_ADDR-1:0] RESET_PC = 32'hBFC00000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              flush,
  input  logic [W_ADDR-1:0] flush_addr,
  input  logic              branch,
  input  logic [W_ADDR-1:0] branch_addr,
  if_fetch_if.master        ibus,
  output logic              if_valid,
  output logic [W_DATA-1:0] if_pc,
  output logic [W_DATA-1:0] if_inst,
  output logic              if_adel
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DROP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic [W_ADDR-1:0] fetch_pc;
  logic [W_ADDR-1:0] req_pc;      // address of the request in flight
  logic              br_pending;
  logic [W_ADDR-1:0] br_target;

  logic              sk_valid;
  logic [W_DATA-1:0] sk_pc;
  logic [W_DATA-1:0] sk_inst;
  logic              sk_adel;

  logic              req_ok;
  logic              inst_req;
  logic              adel_hit;
  logic              addr_acc;
  logic              data_done;
  logic              new_ent;
  logic [W_DATA-1:0] new_pc;
  logic [W_DATA-1:0] new_inst;
  logic              new_adel;
  logic              consume;
  logic              out_free;
  logic              br_take;
  logic              slot_issued;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (flush) begin
      case (state)
        // A response still owed by the slave must be swallowed before refetching,
        // unless it arrives in this very cycle.
        S_WAIT:  state_nx = ibus.inst_data_ok ? S_REQ : S_DROP;
        S_DROP:  state_nx = ibus.inst_data_ok ? S_REQ : S_DROP;
        S_REQ:   state_nx = addr_acc ? S_DROP : S_REQ;
        default: state_nx = S_REQ;
      endcase
    end else begin
      case (state)
        S_IDLE:  state_nx = S_REQ;
        S_REQ: begin
          if (addr_acc) begin
            state_nx = S_WAIT;
          end else if (adel_hit) begin
            state_nx = S_HALT;
          end
        end
        S_WAIT:  state_nx = ibus.inst_data_ok ? S_REQ : S_WAIT;
        S_DROP:  state_nx = ibus.inst_data_ok ? S_REQ : S_DROP;
        S_HALT:  state_nx = S_HALT;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Output and strobe logic
  always_comb begin
    // A full skid buffer blocks new requests, so it can never overflow.
    req_ok      = (state == S_REQ) && !sk_valid;
    inst_req    = req_ok && (fetch_pc[1:0] == 2'b00);
    adel_hit    = req_ok && (fetch_pc[1:0] != 2'b00);
    addr_acc    = inst_req && ibus.inst_addr_ok;
    data_done   = (state == S_WAIT) && ibus.inst_data_ok;

    new_ent     = !flush && (data_done || adel_hit);
    new_pc      = data_done ? req_pc : fetch_pc;
    new_inst    = data_done ? ibus.inst_rdata : '0;
    new_adel    = !data_done;

    consume     = if_valid && !stall;
    out_free    = !if_valid || consume;

    br_take     = branch && !stall;
    // Delay slot is already on its way when it sits in the output register,
    // is in flight, or is being accepted right now.
    slot_issued = if_valid || (state == S_WAIT) || addr_acc;
  end

  assign ibus.inst_req  = inst_req;
  assign ibus.inst_addr = fetch_pc;

  // PC and branch bookkeeping
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc   <= RESET_PC;
      req_pc     <= '0;
      br_pending <= 1'b0;
      br_target  <= '0;
    end else begin
      if (addr_acc) begin
        req_pc <= fetch_pc;
      end

      if (flush) begin
        fetch_pc <= flush_addr;
      end else if (br_take && slot_issued) begin
        fetch_pc <= branch_addr;
      end else if (addr_acc) begin
        fetch_pc <= br_pending ? br_target : fetch_pc + W_ADDR'(4);
      end

      if (flush) begin
        br_pending <= 1'b0;
      end else if (br_take && !slot_issued) begin
        br_pending <= 1'b1;
        br_target  <= branch_addr;
      end else if (addr_acc) begin
        br_pending <= 1'b0;
      end
    end
  end

  // Output register and skid buffer; the skid entry is always older, so it
  // moves forward before a newly arrived entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
      if_adel  <= 1'b0;
      sk_valid <= 1'b0;
      sk_pc    <= '0;
      sk_inst  <= '0;
      sk_adel  <= 1'b0;
    end else if (flush) begin
      if_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else if (out_free) begin
      if (sk_valid) begin
        if_valid <= 1'b1;
        if_pc    <= sk_pc;
        if_inst  <= sk_inst;
        if_adel  <= sk_adel;
        sk_valid <= new_ent;
        if (new_ent) begin
          sk_pc   <= new_pc;
          sk_inst <= new_inst;
          sk_adel <= new_adel;
        end
      end else if (new_ent) begin
        if_valid <= 1'b1;
        if_pc    <= new_pc;
        if_inst  <= new_inst;
        if_adel  <= new_adel;
      end else begin
        if_valid <= 1'b0;
      end
    end else if (new_ent) begin
      sk_valid <= 1'b1;
      sk_pc    <= new_pc;
      sk_inst  <= new_inst;
      sk_adel  <= new_adel;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard testbench for if_fetch
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] EXC_PC   = 32'hBFC00380;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ent_t;

  logic        clk;
  logic        resetn;
  logic        stall;
  logic        flush;
  logic [31:0] flush_addr;
  logic        branch;
  logic [31:0] branch_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .stall       (stall),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .branch      (branch),
    .branch_addr (branch_addr),
    .ibus        (bus),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_adel     (if_adel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_req[$];
  ent_t        exp_ent[$];
  logic [31:0] req_e;
  ent_t        ent_e;

  int          granted = 0;
  int          grant_total = 0;
  int          data_delay = 1;
  bit          dead_en = 0;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] acc_addr = '0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp_v);
  endfunction

  function automatic void push_ent(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
    ent_t e;
    e.pc   = pc;
    e.inst = inst;
    e.adel = adel;
    exp_ent.push_back(e);
  endfunction

  // Slave model: runs once per cycle just after the edge, one request in flight.
  task automatic slave_step();
    bus.inst_data_ok = 1'b0;
    if (!resetn) begin
      pend             = 1'b0;
      bus.inst_addr_ok = 1'b0;
      return;
    end
    if (bus.inst_addr_ok) begin
      pend      = 1'b1;
      pend_addr = acc_addr;
      pend_cnt  = data_delay;
    end
    bus.inst_addr_ok = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = dead_en ? 32'hDEADBEEF : mem(pend_addr);
        pend             = 1'b0;
      end
    end
    if (bus.inst_req === 1'b1 && granted < grant_total) begin
      bus.inst_addr_ok = 1'b1;
      acc_addr         = bus.inst_addr;
      granted++;
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      slave_step();
    end
  endtask

  task automatic grant(input int n);
    grant_total += n;
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    branch      = 1'b0;
    flush_addr  = '0;
    branch_addr = '0;
    data_delay  = 1;
    dead_en     = 0;
    grant_total = granted;
    cyc(2);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_if_adel", 32'(if_adel), 32'd0);
    chk("rst_inst_req", 32'(bus.inst_req), 32'd0);
    chk("rst_inst_addr", bus.inst_addr, RESET_PC);
    resetn = 1'b1;
    chk("rel_req_low", 32'(bus.inst_req), 32'd0);
  endtask

  task automatic drain(input string name);
    chk({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
    chk({name, "_ent_left"}, 32'(exp_ent.size()), 32'd0);
    exp_req.delete();
    exp_ent.delete();
  endtask

  // Request monitor
  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && bus.inst_req === 1'b1 && bus.inst_addr_ok === 1'b1) begin
        if (exp_req.size() == 0) begin
          n_total++;
          $display("FAIL req_unexpected: got %h expected none", bus.inst_addr);
        end else begin
          req_e = exp_req.pop_front();
          chk("req_addr", bus.inst_addr, req_e);
        end
      end
    end
  end

  // Decode-side monitor
  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && if_valid === 1'b1 && stall === 1'b0) begin
        if (exp_ent.size() == 0) begin
          n_total++;
          $display("FAIL ent_unexpected: got pc %h expected none", if_pc);
        end else begin
          ent_e = exp_ent.pop_front();
          chk("ent_pc", if_pc, ent_e.pc);
          chk("ent_inst", if_inst, ent_e.inst);
          chk("ent_adel", 32'(if_adel), 32'(ent_e.adel));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;

    // Reset release, slave always ready
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(RESET_PC + 32'(4 * i));
      push_ent(RESET_PC + 32'(4 * i), mem(RESET_PC + 32'(4 * i)), 1'b0);
    end
    grant(3);
    cyc(1);
    chk("first_req_high", 32'(bus.inst_req), 32'd1);
    cyc(10);
    drain("seq");

    // Stall with A held and B returning into the skid buffer
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(RESET_PC + 32'(4 * i));
      push_ent(RESET_PC + 32'(4 * i), mem(RESET_PC + 32'(4 * i)), 1'b0);
    end
    grant(3);
    cyc(3);
    stall = 1'b1;
    chk("stall_a_held", 32'(if_valid), 32'd1);
    cyc(2);
    chk("stall_noreq1", 32'(bus.inst_req), 32'd0);
    cyc(1);
    chk("stall_noreq2", 32'(bus.inst_req), 32'd0);
    cyc(1);
    stall = 1'b0;
    chk("skid_noreq", 32'(bus.inst_req), 32'd0);
    cyc(8);
    drain("stall");

    // Branch 0x100 -> 0x400 with the delay slot not yet issued
    do_reset();
    cyc(1);
    flush = 1'b1;
    flush_addr = 32'h100;
    cyc(1);
    flush = 1'b0;
    grant(1);
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    exp_req.push_back(32'h400);
    push_ent(32'h100, mem(32'h100), 1'b0);
    push_ent(32'h104, mem(32'h104), 1'b0);
    push_ent(32'h400, mem(32'h400), 1'b0);
    cyc(4);
    branch = 1'b1;
    branch_addr = 32'h400;
    cyc(1);
    branch = 1'b0;
    grant(2);
    cyc(10);
    drain("br_pend");

    // Branch with the delay slot already in the output register
    do_reset();
    cyc(1);
    flush = 1'b1;
    flush_addr = 32'h100;
    cyc(1);
    flush = 1'b0;
    grant(2);
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    exp_req.push_back(32'h400);
    push_ent(32'h100, mem(32'h100), 1'b0);
    push_ent(32'h104, mem(32'h104), 1'b0);
    push_ent(32'h400, mem(32'h400), 1'b0);
    cyc(5);
    chk("slot_in_out", 32'(if_valid), 32'd1);
    branch = 1'b1;
    branch_addr = 32'h400;
    grant(1);
    cyc(1);
    branch = 1'b0;
    chk("br_addr_next", bus.inst_addr, 32'h400);
    cyc(8);
    drain("br_slot");

    // Flush while waiting: late response is discarded
    do_reset();
    data_delay = 4;
    dead_en = 1;
    grant(1);
    exp_req.push_back(RESET_PC);
    exp_req.push_back(EXC_PC);
    push_ent(EXC_PC, mem(EXC_PC), 1'b0);
    cyc(3);
    flush = 1'b1;
    flush_addr = EXC_PC;
    grant(1);
    cyc(1);
    flush = 1'b0;
    cyc(2);
    dead_en = 0;
    data_delay = 1;
    chk("drop_no_valid", 32'(if_valid), 32'd0);
    cyc(8);
    drain("flush_wait");

    // Misaligned PC: address error entry, halt until flush
    do_reset();
    cyc(1);
    flush = 1'b1;
    flush_addr = 32'h202;
    cyc(1);
    flush = 1'b0;
    chk("adel_noreq", 32'(bus.inst_req), 32'd0);
    grant(1);
    push_ent(32'h202, 32'h0, 1'b1);
    push_ent(EXC_PC, mem(EXC_PC), 1'b0);
    exp_req.push_back(EXC_PC);
    cyc(4);
    chk("halt_noreq", 32'(bus.inst_req), 32'd0);
    chk("halt_empty", 32'(if_valid), 32'd0);
    flush = 1'b1;
    flush_addr = EXC_PC;
    cyc(1);
    flush = 1'b0;
    chk("resume_req", 32'(bus.inst_req), 32'd1);
    chk("resume_addr", bus.inst_addr, EXC_PC);
    cyc(6);
    drain("adel");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage MIPS pipeline, and the producer of the `pc`/`inst` pair that the decode stage consumes. It owns the PC register, drives the SRAM-like instruction bus, and delivers one fetched instruction at a time to ID through a one-entry output register backed by a one-entry skid buffer. It applies ID's branch redirect after the delay slot, and takes exception flushes from CP0.

## Interface
- `RESET_PC`, default `32'hBFC00000`: first fetch address after reset.
- `clk` in 1: sole clock; all state updates on rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `stall` in 1: ID not accepting this cycle.
- `flush` in 1: exception/ERET redirect; overrides everything.
- `flush_addr` in `W_ADDR`: redirect target for `flush`.
- `branch` in 1: ID's branch is taken.
- `branch_addr` in `W_ADDR`: target of the taken branch.
- `inst_req` out 1: bus request.
- `inst_addr` out `W_ADDR`: request address.
- `inst_addr_ok` in 1: request accepted this cycle.
- `inst_data_ok` in 1: read data valid this cycle.
- `inst_rdata` in `W_DATA`: read data.
- `if_valid` out 1: output register holds an instruction.
- `if_pc` out `W_DATA`: PC of the held instruction.
- `if_inst` out `W_DATA`: the held instruction.
- `if_adel` out 1: held entry is a fetch address error.

## Operation
- State: `fetch_pc` (next address to request), FSM, output register (`if_*`), skid buffer (`sk_valid`/`sk_pc`/`sk_inst`/`sk_adel`), and `br_pending` with `br_target`.
- FSM states:
  - S_IDLE: reset state.
  - S_REQ: request pending.
  - S_WAIT: one request outstanding.
  - S_DROP: outstanding response to discard.
  - S_HALT: address error raised; wait for flush.
- Transitions:
  - S_IDLE goes to S_REQ unconditionally.
  - S_REQ goes to S_WAIT on `inst_addr_ok`.
  - S_WAIT goes to S_REQ on `inst_data_ok`.
  - S_DROP goes to S_REQ on `inst_data_ok`.
  - S_HALT leaves only on `flush`.
- `inst_req` = (S_REQ) && !`sk_valid` && `fetch_pc[1:0]`==0. At most one request is outstanding.
- `inst_addr` = `fetch_pc`. The address may change while `inst_req` is high without `inst_addr_ok`; the slave samples it only with `inst_addr_ok`.
- On `inst_addr_ok`: `fetch_pc` becomes `br_target` if `br_pending` is set (and `br_pending` clears); otherwise it becomes `fetch_pc`+4, wrapping mod 2^32.
- Address error: in S_REQ with !`sk_valid` and `fetch_pc[1:0]`!=0, no bus request is issued. An entry {pc=`fetch_pc`, inst=0, adel=1} is produced, then the FSM goes to S_HALT.
- Entry placement (bus `inst_data_ok` entries, and address-error entries):
  - ID consumes when `if_valid` && !`stall`.
  - If the output register is empty or consumed this cycle, it loads from the skid buffer first; otherwise it loads the new entry.
  - Any leftover entry goes to the skid buffer.
  - The skid buffer never overflows, because `inst_req` is gated by `sk_valid`.
- Branch (`branch`=1 && !`stall`; ID holds the branch at B; the delay slot is B+4):
  - Slot already issued (`if_valid`, or S_WAIT, or `inst_addr_ok` this cycle): `fetch_pc` is set to `branch_addr` next cycle.
  - Otherwise: set `br_pending`, latch `br_target`. The slot request issues next and the target follows it.
- Flush (`flush`=1), applied regardless of `stall`/`branch`:
  - Clear `if_valid`, `sk_valid`, `br_pending`.
  - `fetch_pc` is set to `flush_addr`.
  - From S_WAIT, or S_REQ with `inst_addr_ok` this cycle: go to S_DROP.
  - From S_DROP: stay in S_DROP.
  - Otherwise: go to S_REQ.
  - A `inst_data_ok` arriving in the flush cycle is discarded.
  - The FSM goes to S_REQ (not S_DROP) when the flush cycle's `inst_data_ok` completes the only outstanding request.

## Timing
- Reset (`resetn`=0 at an edge):
  - FSM goes to S_IDLE; `fetch_pc` is `RESET_PC`.
  - `inst_req`=0, `inst_addr`=`RESET_PC`.
  - `if_valid`=0, `if_pc`=0, `if_inst`=0, `if_adel`=0.
  - `sk_valid`=0, `br_pending`=0.
- Reset mid-transaction drops any outstanding response. The slave is reset together with this block.
- First `inst_req` is asserted in the second cycle after `resetn` rises (S_IDLE, then S_REQ).
- Latency: `addr_ok` in cycle N, `data_ok` in cycle N+1 gives `if_valid` in N+2. Peak throughput is one instruction per 2 cycles.
- `if_*` are registered; `inst_req`/`inst_addr` are combinational from state.

## Test plan
- Reset release, slave always ready:
  - Requests to 0xBFC00000, 0xBFC00004, 0xBFC00008.
  - `if_pc` sequence matches, and `if_inst` equals `rdata` for each.
- `stall` held 4 cycles with entry A in the output register and B returning:
  - B goes to the skid buffer; `inst_req` stays low.
  - After release, A then B are presented, one per cycle.
- ID branch at 0x100 → 0x400, delay slot not yet issued:
  - Requests are 0x104 then 0x400.
  - Repeat with 0x104 already in the output register: the next request is 0x400.
- `flush` to 0xBFC00380 in S_WAIT:
  - The late `data_ok` (0xDEADBEEF) is dropped and `if_valid` stays 0.
  - The next request is 0xBFC00380.
- Flush at 0x202:
  - Output {pc=0x202, inst=0, adel=1}; no `inst_req` is issued.
  - FSM stays in S_HALT until `flush` to 0xBFC00380 resumes fetching.
